// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a single-port unified memory between the
// CPU core (master 0) and a debug/DMA requester (master 1).
module mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_rd_en,
  input  logic          m1_rd_en,
  input  logic          m0_wr_en,
  input  logic          m1_wr_en,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m0_wr_data,
  input  logic [DW-1:0] m1_wr_data,
  output logic [DW-1:0] m0_rd_data,
  output logic [DW-1:0] m1_rd_data,
  output logic          m0_rd_valid,
  output logic          m1_rd_valid,
  output logic          m0_busy,
  output logic          m1_busy,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wr_data,
  input  logic [DW-1:0] mem_rd_data,
  input  logic          mem_rd_valid,
  output logic          err_overrun,
  output logic          err_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE,
    RD_WAIT
  } state_e;

  state_e state_q, state_d;
  logic last_q, last_d;
  logic gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0] pv_q, pv_d;
  logic [1:0] pw_q, pw_d;
  logic [AW-1:0] pa_q [2];
  logic [AW-1:0] pa_d [2];
  logic [DW-1:0] pd_q [2];
  logic [DW-1:0] pd_d [2];

  logic [DW-1:0] rdd_q [2];
  logic [DW-1:0] rdd_d [2];
  logic [1:0] rdv_q, rdv_d;

  logic mem_rd_en_q, mem_rd_en_d;
  logic mem_wr_en_q, mem_wr_en_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wr_data_q, mem_wr_data_d;
  logic err_ov_q, err_ov_d;
  logic err_to_q, err_to_d;

  logic [1:0] in_rd, in_wr;
  logic [AW-1:0] in_addr [2];
  logic [DW-1:0] in_data [2];
  logic [1:0] free;
  logic g;

  assign in_rd      = {m1_rd_en, m0_rd_en};
  assign in_wr      = {m1_wr_en, m0_wr_en};
  assign in_addr[0] = m0_addr;
  assign in_addr[1] = m1_addr;
  assign in_data[0] = m0_wr_data;
  assign in_data[1] = m1_wr_data;

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    gnt_d         = gnt_q;
    cnt_d         = cnt_q;
    pv_d          = pv_q;
    pw_d          = pw_q;
    pa_d          = pa_q;
    pd_d          = pd_q;
    rdd_d         = rdd_q;
    rdv_d         = '0;
    mem_rd_en_d   = 1'b0;
    mem_wr_en_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    err_ov_d      = 1'b0;
    err_to_d      = 1'b0;
    free          = '0;
    g             = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|pv_q) begin
          // On a tie the master that did not win last time goes first
          g          = (pv_q == 2'b11) ? ~last_q : pv_q[1];
          last_d     = g;
          mem_addr_d = pa_q[g];
          if (pw_q[g]) begin
            mem_wr_en_d   = 1'b1;
            mem_wr_data_d = pd_q[g];
            free[g]       = 1'b1;
          end else begin
            mem_rd_en_d = 1'b1;
            gnt_d       = g;
            cnt_d       = '0;
            state_d     = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (mem_rd_valid) begin
          rdd_d[gnt_q] = mem_rd_data;
          rdv_d[gnt_q] = 1'b1;
          free[gnt_q]  = 1'b1;
          state_d      = IDLE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          rdd_d[gnt_q] = '0;
          rdv_d[gnt_q] = 1'b1;
          err_to_d     = 1'b1;
          free[gnt_q]  = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A slot freed on this edge can take a new strobe on the same edge
    for (int i = 0; i < 2; i++) begin
      if (free[i]) pv_d[i] = 1'b0;
      if (in_rd[i] || in_wr[i]) begin
        if (!pv_q[i] || free[i]) begin
          pv_d[i] = 1'b1;
          pw_d[i] = in_wr[i];
          pa_d[i] = in_addr[i];
          pd_d[i] = in_data[i];
        end else begin
          err_ov_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      gnt_q         <= 1'b0;
      cnt_q         <= '0;
      pv_q          <= '0;
      pw_q          <= '0;
      pa_q          <= '{default: '0};
      pd_q          <= '{default: '0};
      rdd_q         <= '{default: '0};
      rdv_q         <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      err_ov_q      <= 1'b0;
      err_to_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      gnt_q         <= gnt_d;
      cnt_q         <= cnt_d;
      pv_q          <= pv_d;
      pw_q          <= pw_d;
      pa_q          <= pa_d;
      pd_q          <= pd_d;
      rdd_q         <= rdd_d;
      rdv_q         <= rdv_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      err_ov_q      <= err_ov_d;
      err_to_q      <= err_to_d;
    end
  end

  assign m0_rd_data  = rdd_q[0];
  assign m1_rd_data  = rdd_q[1];
  assign m0_rd_valid = rdv_q[0];
  assign m1_rd_valid = rdv_q[1];
  assign m0_busy     = pv_q[0];
  assign m1_busy     = pv_q[1];
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign err_overrun = err_ov_q;
  assign err_timeout = err_to_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reads, writes, arbitration order,
// overrun, timeout and reset in the middle of a read.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m0_rd_en = 0, m1_rd_en = 0;
  logic m0_wr_en = 0, m1_wr_en = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wr_data = '0, m1_wr_data = '0;
  logic [DW-1:0] m0_rd_data, m1_rd_data;
  logic m0_rd_valid, m1_rd_valid;
  logic m0_busy, m1_busy;
  logic mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data = '0;
  logic mem_rd_valid = 1'b0;
  logic err_overrun, err_timeout;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_rd_en(m0_rd_en), .m1_rd_en(m1_rd_en),
    .m0_wr_en(m0_wr_en), .m1_wr_en(m1_wr_en),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wr_data(m0_wr_data), .m1_wr_data(m1_wr_data),
    .m0_rd_data(m0_rd_data), .m1_rd_data(m1_rd_data),
    .m0_rd_valid(m0_rd_valid), .m1_rd_valid(m1_rd_valid),
    .m0_busy(m0_busy), .m1_busy(m1_busy),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
    .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    logic seen;

    // Reset state
    tick(); tick();
    chk("rst_mem", {mem_rd_en, mem_wr_en, mem_addr, mem_wr_data}, 64'h0);
    chk("rst_rdd", {m0_rd_data, m1_rd_data}, 64'h0);
    chk("rst_flags", {m0_rd_valid, m1_rd_valid, m0_busy, m1_busy,
                      err_overrun, err_timeout}, 64'h0);
    rst_n = 1'b1;
    tick();

    // Pair A straight after reset: m0 first
    m0_rd_en = 1; m0_addr = 16'h0010;
    m1_rd_en = 1; m1_addr = 16'h0020;
    tick();
    m0_rd_en = 0; m1_rd_en = 0;
    chk("pa_busy", {m0_busy, m1_busy}, 64'h3);
    tick();
    chk("pa_rd0", {mem_rd_en, mem_addr}, {47'h0, 1'b1, 16'h0010});
    tick();
    mem_rd_valid = 1; mem_rd_data = 32'h1111_1111;
    tick();
    mem_rd_valid = 0;
    chk("pa_ret0", {m0_rd_valid, m1_rd_valid, m0_rd_data},
        {30'h0, 2'b10, 32'h1111_1111});
    chk("pa_gap", {mem_rd_en, m1_busy}, 64'h1);
    tick();
    chk("pa_rd1", {mem_rd_en, mem_addr}, {47'h0, 1'b1, 16'h0020});
    tick();
    mem_rd_valid = 1; mem_rd_data = 32'h2222_2222;
    tick();
    mem_rd_valid = 0;
    chk("pa_ret1", {m0_rd_valid, m1_rd_valid, m1_rd_data},
        {30'h0, 2'b01, 32'h2222_2222});
    chk("pa_hold0", m0_rd_data, 64'h1111_1111);
    tick();

    // Single read, memory answers three cycles after mem_rd_en
    m0_rd_en = 1; m0_addr = 16'h0080;
    tick();
    m0_rd_en = 0;
    chk("sr_t1", {m0_busy, mem_rd_en}, 64'h2);
    tick();
    chk("sr_mem", {mem_rd_en, mem_addr}, {47'h0, 1'b1, 16'h0080});
    tick();
    chk("sr_pulse", mem_rd_en, 64'h0);
    tick();
    tick();
    mem_rd_valid = 1; mem_rd_data = 32'h1234_5678;
    tick();
    mem_rd_valid = 0;
    chk("sr_ret", {m0_rd_valid, m1_rd_valid, m0_busy, m0_rd_data},
        {29'h0, 3'b100, 32'h1234_5678});
    tick();
    chk("sr_once", {m0_rd_valid, m1_rd_valid}, 64'h0);

    // Write then read from the same master
    m0_wr_en = 1; m0_addr = 16'h0008; m0_wr_data = 32'hCAFE_0001;
    tick();
    m0_wr_en = 0;
    tick();
    chk("wr_mem", {mem_wr_en, mem_addr, mem_wr_data},
        {15'h0, 1'b1, 16'h0008, 32'hCAFE_0001});
    m0_rd_en = 1; m0_addr = 16'h0000;
    tick();
    m0_rd_en = 0;
    chk("wr_noovr", {err_overrun, mem_wr_en, m0_busy}, 64'h1);
    tick();
    chk("wr_rd", {mem_rd_en, mem_addr}, {47'h0, 1'b1, 16'h0000});
    chk("wr_hold", mem_wr_data, 64'hCAFE_0001);
    tick();
    mem_rd_valid = 1; mem_rd_data = 32'hA5A5_0000;
    tick();
    mem_rd_valid = 0;
    chk("wr_ret", {m0_rd_valid, m0_rd_data}, {31'h0, 1'b1, 32'hA5A5_0000});
    tick();

    // Pair B: m0 won last, so m1 goes first now
    m0_rd_en = 1; m0_addr = 16'h0030;
    m1_rd_en = 1; m1_addr = 16'h0040;
    tick();
    m0_rd_en = 0; m1_rd_en = 0;
    tick();
    chk("pb_rd1", {mem_rd_en, mem_addr}, {47'h0, 1'b1, 16'h0040});
    tick();
    mem_rd_valid = 1; mem_rd_data = 32'h4444_0000;
    tick();
    mem_rd_valid = 0;
    chk("pb_ret1", {m0_rd_valid, m1_rd_valid, m1_rd_data},
        {30'h0, 2'b01, 32'h4444_0000});
    tick();
    chk("pb_rd0", {mem_rd_en, mem_addr}, {47'h0, 1'b1, 16'h0030});
    tick();
    mem_rd_valid = 1; mem_rd_data = 32'h3333_0000;
    tick();
    mem_rd_valid = 0;
    chk("pb_ret0", {m0_rd_valid, m1_rd_valid, m0_rd_data},
        {30'h0, 2'b10, 32'h3333_0000});
    tick();

    // Overrun while m1 read is outstanding
    m1_rd_en = 1; m1_addr = 16'h0050;
    tick();
    m1_rd_en = 0;
    tick();
    chk("ov_rd", {mem_rd_en, mem_addr}, {47'h0, 1'b1, 16'h0050});
    tick();
    m1_rd_en = 1; m1_addr = 16'h0060;
    tick();
    m1_rd_en = 0;
    chk("ov_err", err_overrun, 64'h1);
    tick();
    chk("ov_once", err_overrun, 64'h0);
    mem_rd_valid = 1; mem_rd_data = 32'h5555_0000;
    tick();
    mem_rd_valid = 0;
    chk("ov_ret", {m1_rd_valid, m1_rd_data}, {31'h0, 1'b1, 32'h5555_0000});
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_rd_en || m1_busy) seen = 1'b1;
    end
    chk("ov_drop", seen, 64'h0);

    // Timeout: memory never answers
    m0_rd_en = 1; m0_addr = 16'h0070;
    tick();
    m0_rd_en = 0;
    tick();
    chk("to_rd", {mem_rd_en, mem_addr}, {47'h0, 1'b1, 16'h0070});
    n = 0;
    seen = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (m0_rd_valid) begin
        n = i;
        break;
      end
      if (err_timeout) seen = 1'b1;
    end
    chk("to_lat", n, 64'd256);
    chk("to_early", seen, 64'h0);
    chk("to_ret", {err_timeout, m0_rd_valid, m0_busy, m0_rd_data},
        {29'h0, 3'b110, 32'h0});
    m1_wr_en = 1; m1_addr = 16'h0090; m1_wr_data = 32'h0000_BEEF;
    tick();
    m1_wr_en = 0;
    chk("to_once", err_timeout, 64'h0);
    tick();
    chk("to_next", {mem_wr_en, mem_addr, mem_wr_data},
        {15'h0, 1'b1, 16'h0090, 32'h0000_BEEF});
    tick();

    // Reset during RD_WAIT, late completion is ignored
    m0_rd_en = 1; m0_addr = 16'h00A0;
    tick();
    m0_rd_en = 0;
    tick();
    chk("rr_rd", mem_rd_en, 64'h1);
    rst_n = 1'b0;
    tick();
    chk("rr_mem", {mem_rd_en, mem_wr_en, mem_addr, mem_wr_data}, 64'h0);
    chk("rr_rdd", {m0_rd_data, m1_rd_data}, 64'h0);
    rst_n = 1'b1;
    mem_rd_valid = 1; mem_rd_data = 32'hDEAD_BEEF;
    tick();
    mem_rd_valid = 0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (m0_rd_valid || m1_rd_valid || m0_busy || m1_busy ||
          mem_rd_en || err_timeout) seen = 1'b1;
    end
    chk("rr_quiet", seen, 64'h0);
    chk("rr_out", {m0_rd_data, m1_rd_data}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
